// File: rtl/mdu_pkg.sv
// Shared types and helpers for the RV64M multiply/divide sequencer.
// Optional build macro used by the sequencer: MDU_EARLY_OUT_EN.
package mdu_pkg;

    localparam int XLEN_DEF = 64;

    // M-extension operation encoding (Func3)
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    // Divide/remainder class uses the restoring divider datapath
    function automatic logic is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // rs1 is interpreted as two's complement
    function automatic logic is_signed_a(input mdu_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is interpreted as two's complement
    function automatic logic is_signed_b(input mdu_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the multiply (add/shift) or restoring divide (shift/subtract) datapath.
// Multiply: acc += mcand when opnd LSB set; mcand shifts left, opnd (multiplier) shifts right.
// Divide:   acc = {remainder, dividend/quotient}; shift left one bit, subtract divisor (opnd)
//           from the upper half when it fits and set the new quotient bit.
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              div_mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [2*XLEN-1:0] mcand,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_next,
    output logic [2*XLEN-1:0] mcand_next,
    output logic [XLEN-1:0]   opnd_next
);

    logic [XLEN:0]   trial_s;
    logic            fits_s;
    logic [XLEN-1:0] rem_sub_s;

    // Divide trial: shifted partial remainder (one extra bit) against the divisor.
    // The difference is exact in XLEN bits whenever the divisor fits.
    always_comb begin
        trial_s   = acc[2*XLEN-1:XLEN-1];
        fits_s    = (trial_s >= {1'b0, opnd});
        rem_sub_s = trial_s[XLEN-1:0] - opnd;
    end

    // Select the multiply or divide step
    always_comb begin
        acc_next   = acc;
        mcand_next = mcand;
        opnd_next  = opnd;
        if (div_mode) begin
            if (fits_s) begin
                acc_next = {rem_sub_s, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            if (opnd[0]) begin
                acc_next = acc + mcand;
            end else begin
                acc_next = acc;
            end
            mcand_next = {mcand[2*XLEN-2:0], 1'b0};
            opnd_next  = {1'b0, opnd[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV64M multiply/divide sequencer: shift-add multiply and restoring divide,
// one bit per cycle, behind valid/ready handshakes. Operands are converted to magnitudes
// at accept, the sign is fixed up when the result is written on the last CALC edge.
// Build macro MDU_EARLY_OUT_EN: multiplies leave CALC once the shifted multiplier is zero.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            ReqValid,
    output logic            ReqReady,
    input  logic [2:0]      Func3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            Kill,
    output logic            RespValid,
    input  logic            RespReady,
    output logic [XLEN-1:0] Result,
    output logic            Busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0]   ZERO_X = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);

    mdu_state_e        state_r;
    mdu_op_e           op_r;
    logic [2*XLEN-1:0] acc_r;
    logic [2*XLEN-1:0] mcand_r;
    logic [XLEN-1:0]   opnd_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              neg_q_r;
    logic              neg_rem_r;
    logic [XLEN-1:0]   result_r;
    logic              resp_valid_r;
    logic              busy_r;

    mdu_op_e           op_in_s;
    logic              sign_a_s;
    logic              sign_b_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic              special_s;
    logic [XLEN-1:0]   special_result_s;

    logic [2*XLEN-1:0] acc_nxt_s;
    logic [2*XLEN-1:0] mcand_nxt_s;
    logic [XLEN-1:0]   opnd_nxt_s;
    logic              last_step_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   final_result_s;

    assign ReqReady  = (state_r == ST_IDLE);
    assign RespValid = resp_valid_r;
    assign Result    = result_r;
    assign Busy      = busy_r;

    // Accept-time decode: operand signs, magnitudes and the no-iteration special cases
    always_comb begin
        op_in_s  = mdu_op_e'(Func3);
        sign_a_s = is_signed_a(op_in_s) & A[XLEN-1];
        sign_b_s = is_signed_b(op_in_s) & B[XLEN-1];
        if (sign_a_s) begin
            mag_a_s = ~A + ONE_X;
        end else begin
            mag_a_s = A;
        end
        if (sign_b_s) begin
            mag_b_s = ~B + ONE_X;
        end else begin
            mag_b_s = B;
        end
        special_s        = 1'b0;
        special_result_s = ZERO_X;
        if (is_div(op_in_s) && (B == ZERO_X)) begin
            special_s = 1'b1;
            if ((op_in_s == OP_DIV) || (op_in_s == OP_DIVU)) begin
                special_result_s = ONES_X;
            end else begin
                special_result_s = A;
            end
        end else if (((op_in_s == OP_DIV) || (op_in_s == OP_REM)) &&
                     (A == MIN_X) && (B == ONES_X)) begin
            special_s = 1'b1;
            if (op_in_s == OP_DIV) begin
                special_result_s = MIN_X;
            end else begin
                special_result_s = ZERO_X;
            end
        end else begin
            special_s        = 1'b0;
            special_result_s = ZERO_X;
        end
    end

    mdu_iter_step #(
        .XLEN(XLEN)
    ) u_step (
        .div_mode   (is_div(op_r)),
        .acc        (acc_r),
        .mcand      (mcand_r),
        .opnd       (opnd_r),
        .acc_next   (acc_nxt_s),
        .mcand_next (mcand_nxt_s),
        .opnd_next  (opnd_nxt_s)
    );

    // Termination of the CALC phase
    always_comb begin
`ifdef MDU_EARLY_OUT_EN
        if (cnt_r == CNT_ZERO) begin
            last_step_s = 1'b1;
        end else if (!is_div(op_r) && (opnd_nxt_s == ZERO_X)) begin
            last_step_s = 1'b1;
        end else begin
            last_step_s = 1'b0;
        end
`else
        if (cnt_r == CNT_ZERO) begin
            last_step_s = 1'b1;
        end else begin
            last_step_s = 1'b0;
        end
`endif
    end

    // Sign fix-up and result select from the final iteration's accumulator
    always_comb begin
        if (neg_q_r) begin
            prod_s = ~acc_nxt_s + ONE_2X;
        end else begin
            prod_s = acc_nxt_s;
        end
        if (neg_q_r) begin
            quo_s = ~acc_nxt_s[XLEN-1:0] + ONE_X;
        end else begin
            quo_s = acc_nxt_s[XLEN-1:0];
        end
        if (neg_rem_r) begin
            rem_s = ~acc_nxt_s[2*XLEN-1:XLEN] + ONE_X;
        end else begin
            rem_s = acc_nxt_s[2*XLEN-1:XLEN];
        end
        case (op_r)
            OP_MUL:                       final_result_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_result_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_result_s = quo_s;
            OP_REM, OP_REMU:              final_result_s = rem_s;
            default:                      final_result_s = ZERO_X;
        endcase
    end

    // Sequencer FSM with registered handshake, busy and result
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            op_r         <= OP_MUL;
            acc_r        <= {(2*XLEN){1'b0}};
            mcand_r      <= {(2*XLEN){1'b0}};
            opnd_r       <= ZERO_X;
            cnt_r        <= CNT_ZERO;
            neg_q_r      <= 1'b0;
            neg_rem_r    <= 1'b0;
            result_r     <= ZERO_X;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else if (Kill) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            result_r     <= ZERO_X;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ReqValid) begin
                        op_r      <= op_in_s;
                        neg_q_r   <= sign_a_s ^ sign_b_s;
                        neg_rem_r <= sign_a_s;
                        busy_r    <= 1'b1;
                        if (special_s) begin
                            result_r <= special_result_s;
                            state_r  <= ST_DONE;
                        end else begin
                            // Divide: upper half is the partial remainder, lower half the dividend
                            if (is_div(op_in_s)) begin
                                acc_r <= {ZERO_X, mag_a_s};
                            end else begin
                                acc_r <= {(2*XLEN){1'b0}};
                            end
                            mcand_r <= {ZERO_X, mag_a_s};
                            opnd_r  <= mag_b_s;
                            cnt_r   <= CNT_LAST;
                            state_r <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_r   <= acc_nxt_s;
                    mcand_r <= mcand_nxt_s;
                    opnd_r  <= opnd_nxt_s;
                    if (last_step_s) begin
                        result_r <= final_result_s;
                        cnt_r    <= CNT_ZERO;
                        state_r  <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (!resp_valid_r) begin
                        resp_valid_r <= 1'b1;
                    end else if (RespReady) begin
                        resp_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        resp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

endmodule
